operator_cmd_sequencer: RTL and testbench



---
 rtl/operator_pkg.sv | 24 ++
 rtl/operator_cmd_sequencer_if.sv | 32 +++
 rtl/opseq_cycle_timer.sv | 24 ++
 rtl/operator_cmd_sequencer.sv | 153 +++++++++++++++
 tb/tb_operator_cmd_sequencer.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/operator_pkg.sv
// Shared types and constants for the operator command sequencer.
package operator_pkg;

  typedef enum logic [1:0] {
    OP_NONE    = 2'd0,
    OP_ADD_SUB = 2'd1,
    OP_SUB_SUB = 2'd2
  } op_e;

  localparam int unsigned OP_REG_ADDR_DEF = 10;

  typedef enum logic [2:0] {
    IDLE,
    CFG,
    GAP,
    CALC,
    RSP
  } opseq_state_e;

  function automatic logic op_legal(input logic [1:0] op);
    return (op == 2'(OP_ADD_SUB)) || (op == 2'(OP_SUB_SUB));
  endfunction

endpackage

// File: rtl/operator_cmd_sequencer_if.sv
// Command/response handshake plus operator register/operand bus.
interface operator_cmd_sequencer_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [DATA_W-1:0] cmd_c;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [63:0]       rsp_z;
  logic              rsp_err;
  logic              reg_wr;
  logic [DATA_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wr_data;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] c;
  logic [63:0]       z;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_c, rsp_ready, z,
    output cmd_ready, rsp_valid, rsp_z, rsp_err, reg_wr, reg_addr, reg_wr_data, a, b, c
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_c, rsp_ready, z,
    input  cmd_ready, rsp_valid, rsp_z, rsp_err, reg_wr, reg_addr, reg_wr_data, a, b, c
  );
endinterface

// File: rtl/opseq_cycle_timer.sv
// Loadable down-counter shared by the CFG/GAP/CALC phases; done when it reaches zero.
module opseq_cycle_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] cnt_init,
  output logic             done
);
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= cnt_init;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign done = (cnt_q == '0);
endmodule

// File: rtl/operator_cmd_sequencer.sv
// Command front-end for the operator IP: programs op type, drives operands, samples z.
// Optional op-type cache enabled by defining OPSEQ_CFG_CACHE_EN.
module operator_cmd_sequencer
  import operator_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned OP_REG_ADDR = OP_REG_ADDR_DEF,
  parameter int unsigned WR_CYC      = 2,
  parameter int unsigned GAP_CYC     = 2,
  parameter int unsigned CALC_LAT    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  operator_cmd_sequencer_if.slave   bus
);
  localparam int unsigned CNT_W = 16;

  opseq_state_e      state_q, state_d;
  logic              pend_q, pend_d;
  logic              rdy_q;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] ca_q, cb_q, cc_q;
  logic              reg_wr_q, rsp_valid_q, rsp_err_q;
  logic [DATA_W-1:0] reg_addr_q, reg_wr_data_q, a_q, b_q, c_q;
  logic [63:0]       rsp_z_q;
  logic              tmr_load, tmr_done;
  logic [CNT_W-1:0]  tmr_init;
  logic              cfg_hit;
  logic              accept;

  assign accept = bus.cmd_valid && rdy_q;

`ifdef OPSEQ_CFG_CACHE_EN
  logic       cache_vld_q;
  logic [1:0] cache_op_q;
  assign cfg_hit = cache_vld_q && (cache_op_q == op_q);
`else
  assign cfg_hit = 1'b0;
`endif

  opseq_cycle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .cnt_init (tmr_init),
    .done     (tmr_done)
  );

  // The accept edge only registers the command; the decode happens one cycle later
  // in IDLE (pend_q), which is what places every phase one cycle after T.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    tmr_load = 1'b0;
    tmr_init = '0;
    unique case (state_q)
      IDLE: begin
        if (pend_q) begin
          pend_d = 1'b0;
          if (!op_legal(op_q))  state_d = RSP;
          else if (cfg_hit)     state_d = CALC;
          else                  state_d = CFG;
        end else if (accept) begin
          pend_d = 1'b1;
        end
      end
      CFG:  if (tmr_done) state_d = (GAP_CYC == 0) ? CALC : GAP;
      GAP:  if (tmr_done) state_d = CALC;
      CALC: if (tmr_done) state_d = RSP;
      RSP:  if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    tmr_load = (state_d != state_q) && (state_d inside {CFG, GAP, CALC});
    case (state_d)
      CFG:     tmr_init = CNT_W'(WR_CYC - 1);
      GAP:     tmr_init = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
      default: tmr_init = CNT_W'(CALC_LAT - 1);
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      pend_q        <= 1'b0;
      rdy_q         <= 1'b0;
      op_q          <= '0;
      ca_q          <= '0;
      cb_q          <= '0;
      cc_q          <= '0;
      reg_wr_q      <= 1'b0;
      reg_addr_q    <= '0;
      reg_wr_data_q <= '0;
      a_q           <= '0;
      b_q           <= '0;
      c_q           <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_z_q       <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      rdy_q       <= (state_d == IDLE) && !pend_d;
      reg_wr_q    <= (state_d == CFG);
      rsp_valid_q <= (state_d == RSP);
      if (accept) begin
        op_q <= bus.cmd_op;
        ca_q <= bus.cmd_a;
        cb_q <= bus.cmd_b;
        cc_q <= bus.cmd_c;
      end
      if (state_d == CFG && state_q != CFG) begin
        reg_addr_q    <= DATA_W'(OP_REG_ADDR);
        reg_wr_data_q <= DATA_W'(op_q);
      end
      if (state_d == CALC && state_q != CALC) begin
        a_q <= ca_q;
        b_q <= cb_q;
        c_q <= cc_q;
      end
      if (state_q == CALC && state_d == RSP) begin
        rsp_z_q   <= bus.z;
        rsp_err_q <= 1'b0;
      end else if (state_q == IDLE && state_d == RSP) begin
        rsp_z_q   <= '0;
        rsp_err_q <= 1'b1;
      end
    end
  end

`ifdef OPSEQ_CFG_CACHE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cache_vld_q <= 1'b0;
      cache_op_q  <= '0;
    end else if (state_q == CFG && state_d != CFG) begin
      cache_vld_q <= 1'b1;
      cache_op_q  <= op_q;
    end
  end
`endif

  assign bus.cmd_ready   = rdy_q;
  assign bus.reg_wr      = reg_wr_q;
  assign bus.reg_addr    = reg_addr_q;
  assign bus.reg_wr_data = reg_wr_data_q;
  assign bus.a           = a_q;
  assign bus.b           = b_q;
  assign bus.c           = c_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_z       = rsp_z_q;
  assign bus.rsp_err     = rsp_err_q;
endmodule

// File: tb/tb_operator_cmd_sequencer.sv
// Directed bench for operator_cmd_sequencer with a small operator model driving z.
module tb_operator_cmd_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  operator_cmd_sequencer_if #(.DATA_W(32)) bus_if ();

  operator_cmd_sequencer #(
    .DATA_W      (32),
    .OP_REG_ADDR (10),
    .WR_CYC      (2),
    .GAP_CYC     (2),
    .CALC_LAT    (4)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // Operator IP stand-in: op register written over the register bus, z combinational.
  logic [1:0] op_reg = 2'd0;
  always @(posedge clk)
    if (bus_if.reg_wr && bus_if.reg_addr == 32'd10) op_reg <= bus_if.reg_wr_data[1:0];

  always_comb begin
    bus_if.z = 64'd0;
    if (op_reg == 2'd1) bus_if.z = 64'(bus_if.a) + 64'(bus_if.b) - 64'(bus_if.c);
    else if (op_reg == 2'd2) bus_if.z = 64'(bus_if.a) - 64'(bus_if.b) - 64'(bus_if.c);
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input int exp_lat, input int exp_wr, input int exp_ak,
                         input logic [31:0] exp_data, input logic [63:0] exp_z, input logic exp_err,
                         input logic [31:0] exp_a, input logic [31:0] exp_b, input logic [31:0] exp_c);
    int k;
    int wr_n;
    int ak;
    logic [31:0] a0;
    bus_if.cmd_op    = op;
    bus_if.cmd_a     = a;
    bus_if.cmd_b     = b;
    bus_if.cmd_c     = c;
    bus_if.cmd_valid = 1'b1;
    chk({tag, ".cmd_ready"}, 64'(bus_if.cmd_ready), 64'd1);
    a0 = bus_if.a;
    tick();
    bus_if.cmd_valid = 1'b0;
    k = 0; wr_n = 0; ak = 0;
    while (!bus_if.rsp_valid && k < 40) begin
      tick();
      k++;
      if (bus_if.reg_wr) wr_n++;
      if (ak == 0 && bus_if.a !== a0) ak = k;
    end
    chk({tag, ".latency"}, 64'(k), 64'(exp_lat));
    chk({tag, ".reg_wr_cycles"}, 64'(wr_n), 64'(exp_wr));
    if (exp_ak > 0) chk({tag, ".abc_load_cycle"}, 64'(ak), 64'(exp_ak));
    chk({tag, ".reg_addr"}, 64'(bus_if.reg_addr), 64'd10);
    chk({tag, ".reg_wr_data"}, 64'(bus_if.reg_wr_data), 64'(exp_data));
    chk({tag, ".rsp_z"}, bus_if.rsp_z, exp_z);
    chk({tag, ".rsp_err"}, 64'(bus_if.rsp_err), 64'(exp_err));
    chk({tag, ".a"}, 64'(bus_if.a), 64'(exp_a));
    chk({tag, ".b"}, 64'(bus_if.b), 64'(exp_b));
    chk({tag, ".c"}, 64'(bus_if.c), 64'(exp_c));
  endtask

  task automatic take_rsp(input string tag, input int hold, input logic [63:0] exp_z);
    for (int i = 0; i < hold; i++) begin
      bus_if.rsp_ready = 1'b0;
      tick();
      chk({tag, ".hold_valid"}, 64'(bus_if.rsp_valid), 64'd1);
      chk({tag, ".hold_z"}, bus_if.rsp_z, exp_z);
      chk({tag, ".hold_cmd_ready"}, 64'(bus_if.cmd_ready), 64'd0);
    end
    bus_if.rsp_ready = 1'b1;
    tick();
    bus_if.rsp_ready = 1'b0;
    chk({tag, ".post_valid"}, 64'(bus_if.rsp_valid), 64'd0);
    chk({tag, ".post_cmd_ready"}, 64'(bus_if.cmd_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_op    = 2'd0;
    bus_if.cmd_a     = '0;
    bus_if.cmd_b     = '0;
    bus_if.cmd_c     = '0;
    bus_if.rsp_ready = 1'b0;

    repeat (3) tick();
    chk("por.cmd_ready", 64'(bus_if.cmd_ready), 64'd0);
    chk("por.rsp_valid", 64'(bus_if.rsp_valid), 64'd0);
    rst = 1'b1;
    tick();
    chk("por.release_ready", 64'(bus_if.cmd_ready), 64'd1);

    // Test 1: reset while in CALC
    bus_if.cmd_op = 2'd2; bus_if.cmd_a = 32'd1; bus_if.cmd_b = 32'd2; bus_if.cmd_c = 32'd3;
    bus_if.cmd_valid = 1'b1;
    tick();
    bus_if.cmd_valid = 1'b0;
    repeat (6) tick();
    chk("t1.in_calc_a", 64'(bus_if.a), 64'd1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t1.rst_reg_wr", 64'(bus_if.reg_wr), 64'd0);
      chk("t1.rst_abc", 64'(bus_if.a | bus_if.b | bus_if.c), 64'd0);
      chk("t1.rst_rsp_valid", 64'(bus_if.rsp_valid), 64'd0);
      chk("t1.rst_cmd_ready", 64'(bus_if.cmd_ready), 64'd0);
      tick();
    end
    rst = 1'b1;
    tick();
    chk("t1.release_ready", 64'(bus_if.cmd_ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus_if.rsp_valid) seen = 1'b1;
    end
    chk("t1.no_response", 64'(seen), 64'd0);

    // Test 2/3: full config path
    run_cmd("t2", 2'd1, 32'd100, 32'd50, 32'd10, 9, 2, 5, 32'd1, 64'd140, 1'b0, 32'd100, 32'd50, 32'd10);
    take_rsp("t2", 0, 64'd140);
    run_cmd("t3", 2'd2, 32'd100, 32'd50, 32'd10, 9, 2, 0, 32'd2, 64'd40, 1'b0, 32'd100, 32'd50, 32'd10);
    take_rsp("t3", 0, 64'd40);

    // Test 4: same op again
`ifdef OPSEQ_CFG_CACHE_EN
    run_cmd("t4", 2'd2, 32'd7, 32'd3, 32'd1, 5, 0, 1, 32'd2, 64'd3, 1'b0, 32'd7, 32'd3, 32'd1);
`else
    run_cmd("t4", 2'd2, 32'd7, 32'd3, 32'd1, 9, 2, 5, 32'd2, 64'd3, 1'b0, 32'd7, 32'd3, 32'd1);
`endif
    take_rsp("t4", 0, 64'd3);

    // Test 5: illegal op, then the cached op again
    run_cmd("t5", 2'd3, 32'd9, 32'd9, 32'd9, 1, 0, 0, 32'd2, 64'd0, 1'b1, 32'd7, 32'd3, 32'd1);
    take_rsp("t5", 0, 64'd0);
`ifdef OPSEQ_CFG_CACHE_EN
    run_cmd("t5b", 2'd2, 32'd20, 32'd5, 32'd5, 5, 0, 1, 32'd2, 64'd10, 1'b0, 32'd20, 32'd5, 32'd5);
`else
    run_cmd("t5b", 2'd2, 32'd20, 32'd5, 32'd5, 9, 2, 5, 32'd2, 64'd10, 1'b0, 32'd20, 32'd5, 32'd5);
`endif

    // Test 6: stalled response with the next command already waiting
    bus_if.cmd_op = 2'd1; bus_if.cmd_a = 32'd1000; bus_if.cmd_b = 32'd1; bus_if.cmd_c = 32'd1;
    bus_if.cmd_valid = 1'b1;
    take_rsp("t6", 20, 64'd10);
    run_cmd("t6b", 2'd1, 32'd1000, 32'd1, 32'd1, 9, 2, 5, 32'd1, 64'd1000, 1'b0, 32'd1000, 32'd1, 32'd1);
    take_rsp("t6b", 0, 64'd1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
